mealy_non_overlap: RTL and testbench

- Serial-bit Mealy sequence detector; one input bit is sampled per clock.
- Asserts y in the same cycle that the final bit of PATTERN is present on a, so the output is combinational from the current state and a.
- Matches do not overlap: after a detection, matching restarts from the empty state.
- Used as a leaf pattern-spotter on a 1-bit serial stream. The default pattern is 1011.

---
 rtl/mealy_non_overlap.sv | 105 ++++++++++
 tb/tb_mealy_non_overlap.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mealy_non_overlap.sv
// ----------------------------------------------------------------------------
// mealy_non_overlap
//
// Serial-bit Mealy sequence detector. One bit of the stream is taken on a per
// rising clock edge; y is raised combinationally in the cycle where the
// current state together with a completes PATTERN. After a detection the
// matcher restarts from the empty state, so detections never overlap.
//
// PATTERN[LEN-1] is the first bit expected on the stream.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   res  - synchronous active-low reset; also forces y low while asserted
//   a    - serial data bit
//   y    - detect flag (Mealy), valid while a is stable before the edge
// ----------------------------------------------------------------------------
module mealy_non_overlap #(
    parameter int              LEN     = 4,
    parameter logic [LEN-1:0]  PATTERN = 4'b1011
) (
    input  logic clk,
    input  logic res,
    input  logic a,
    output logic y
);

    localparam int SW = (LEN > 1) ? $clog2(LEN) : 1;

    typedef logic [SW-1:0] state_t;

    localparam state_t IDLE = '0;

    // i-th bit of the pattern in stream order (i = 0 is received first).
    function automatic logic pat_bit(input int i);
        logic [LEN-1:0] t;
        t = PATTERN >> (LEN - 1 - i);
        return t[0];
    endfunction

    // Longest proper prefix of PATTERN that is a suffix of the k matched
    // pattern bits followed by b. Candidates are tried longest first, so the
    // first hit is the answer.
    function automatic int fallback(input int k, input logic b);
        int   best;
        logic ok;
        logic sbit;
        int   j;
        best = 0;
        for (int l = k; l >= 1; l--) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                j    = k + 1 - l + i;
                sbit = (j == k) ? b : pat_bit(j);
                if (pat_bit(i) != sbit) ok = 1'b0;
            end
            if (ok && (best == 0)) best = l;
        end
        return best;
    endfunction

    // Per-state expected bit and mismatch targets, built from PATTERN.
    logic   exp_bit [LEN];
    state_t fb0     [LEN];
    state_t fb1     [LEN];

    for (genvar g = 0; g < LEN; g++) begin : g_tab
        assign exp_bit[g] = pat_bit(g);
        assign fb0[g]     = state_t'(fallback(g, 1'b0));
        assign fb1[g]     = state_t'(fallback(g, 1'b1));
    end

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        y       = 1'b0;
        if (!res) begin
            state_d = IDLE;
            y       = 1'b0;
        end else if (int'(state_q) >= LEN) begin
            // Encodings beyond the pattern length are never entered normally.
            state_d = IDLE;
        end else if (a == exp_bit[state_q]) begin
            if (int'(state_q) == LEN - 1) begin
                // Full match: flag it and restart from empty (no overlap).
                y       = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = state_q + state_t'(1);
            end
        end else begin
            state_d = a ? fb1[state_q] : fb0[state_q];
        end
    end

endmodule

// File: tb/tb_mealy_non_overlap.sv
module tb_mealy_non_overlap;

    logic clk;
    logic res;
    logic a;
    logic y;

    logic res3;
    logic a3;
    logic y3;

    int tests_run;
    int tests_failed;

    mealy_non_overlap #(
        .LEN     (4),
        .PATTERN (4'b1011)
    ) dut (
        .clk (clk),
        .res (res),
        .a   (a),
        .y   (y)
    );

    mealy_non_overlap #(
        .LEN     (3),
        .PATTERN (3'b110)
    ) dut3 (
        .clk (clk),
        .res (res3),
        .a   (a3),
        .y   (y3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bit at the falling edge; y is then looked at 1 ns later,
    // well away from the next rising edge.
    task automatic drive_bit(input logic b);
        @(negedge clk);
        a = b;
        #1;
    endtask

    task automatic drive_bit3(input logic b);
        @(negedge clk);
        a3 = b;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        res = 1'b0;
        a   = 1'b0;
        @(negedge clk);
        res = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] stim;
        logic [3:0] exp;
        @(negedge clk);
        res = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_bit(i[0] ? 1'b0 : 1'b1);
            tests_run++;
            if (y !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold cyc%0d: y=%b expected 0", i, y);
            end
        end
        @(negedge clk);
        res  = 1'b1;
        stim = 4'b1011;
        exp  = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            drive_bit(stim[i]);
            tests_run++;
            if (y !== exp[i]) begin
                tests_failed++;
                $display("FAIL reset_release bit%0d: y=%b expected %b", 4 - i, y, exp[i]);
            end
        end
    endtask

    task automatic test_non_overlap();
        logic [6:0] stim;
        logic [6:0] exp;
        apply_reset();
        stim = 7'b1011011;
        exp  = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            drive_bit(stim[i]);
            tests_run++;
            if (y !== exp[i]) begin
                tests_failed++;
                $display("FAIL non_overlap bit%0d: y=%b expected %b", 7 - i, y, exp[i]);
            end
        end
    endtask

    task automatic test_fallback();
        logic [5:0] stim;
        logic [5:0] exp;
        apply_reset();
        stim = 6'b101011;
        exp  = 6'b000001;
        for (int i = 5; i >= 0; i--) begin
            drive_bit(stim[i]);
            tests_run++;
            if (y !== exp[i]) begin
                tests_failed++;
                $display("FAIL fallback bit%0d: y=%b expected %b", 6 - i, y, exp[i]);
            end
        end
    endtask

    task automatic test_long_stream();
        logic [11:0] stim;
        logic [11:0] exp;
        apply_reset();
        stim = 12'b1011_1010_1011;
        exp  = 12'b0001_0000_0001;
        for (int i = 11; i >= 0; i--) begin
            drive_bit(stim[i]);
            tests_run++;
            if (y !== exp[i]) begin
                tests_failed++;
                $display("FAIL long_stream bit%0d: y=%b expected %b", 12 - i, y, exp[i]);
            end
            if (exp[i]) begin
                @(posedge clk);
                #1;
                tests_run++;
                if (dut.state_q !== 2'd0) begin
                    tests_failed++;
                    $display("FAIL long_stream_idle bit%0d: state=%0d expected 0", 12 - i, dut.state_q);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] stim;
        logic [3:0] exp;
        apply_reset();
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        // Now one bit short of a match; reset must both mask y and discard it.
        @(negedge clk);
        res = 1'b0;
        a   = 1'b1;
        #1;
        tests_run++;
        if (y !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_mask: y=%b expected 0", y);
        end
        @(negedge clk);
        res = 1'b1;
        a   = 1'b1;
        #1;
        tests_run++;
        if (y !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_discard: y=%b expected 0", y);
        end
        apply_reset();
        stim = 4'b1011;
        exp  = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            drive_bit(stim[i]);
            tests_run++;
            if (y !== exp[i]) begin
                tests_failed++;
                $display("FAIL mid_reset_after bit%0d: y=%b expected %b", 4 - i, y, exp[i]);
            end
        end
    endtask

    task automatic test_param_110();
        logic [6:0] stim;
        logic [6:0] exp;
        @(negedge clk);
        res3 = 1'b0;
        a3   = 1'b0;
        @(negedge clk);
        res3 = 1'b1;
        stim = 7'b1110110;
        exp  = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            drive_bit3(stim[i]);
            tests_run++;
            if (y3 !== exp[i]) begin
                tests_failed++;
                $display("FAIL param_110 bit%0d: y=%b expected %b", 7 - i, y3, exp[i]);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        res  = 1'b0;
        a    = 1'b0;
        res3 = 1'b0;
        a3   = 1'b0;
        test_reset();
        test_non_overlap();
        test_fallback();
        test_long_stream();
        test_mid_reset();
        test_param_110();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
